// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Read returns are routed back to the issuing port through a tag pipeline.
module ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_q,
  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_q,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  logic                prio;
  logic                rd_issue;
  logic [READ_LAT-1:0] tag_vld;
  logic [READ_LAT-1:0] tag_id;

  // prio names the port that wins when both request
  always_comb begin
    p0_gnt = ~reset & p0_req & (~p1_req | ~prio);
    p1_gnt = ~reset & p1_req & (~p0_req | prio);
  end

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    unique case (1'b1)
      p0_gnt: begin
        ram_address = p0_address;
        ram_data    = p0_data;
        ram_wren    = p0_wren;
      end
      p1_gnt: begin
        ram_address = p1_address;
        ram_data    = p1_data;
        ram_wren    = p1_wren;
      end
      default: ;
    endcase
  end

  assign rd_issue = (p0_gnt & ~p0_wren) | (p1_gnt & ~p1_wren);

  always_ff @(posedge clock) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (p0_gnt) begin
      prio <= 1'b1;
    end else if (p1_gnt) begin
      prio <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= rd_issue;
      tag_id[0]  <= p1_gnt;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    p0_rvalid = ~reset & tag_vld[READ_LAT-1] & ~tag_id[READ_LAT-1];
    p1_rvalid = ~reset & tag_vld[READ_LAT-1] & tag_id[READ_LAT-1];
    p0_q      = ram_q;
    p1_q      = ram_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural READ_LAT RAM.
// Outputs are sampled on the falling edge; inputs change 1 after rising.
module tb_ram_arbiter;

  localparam int LAT = 2;

  logic        clock;
  logic        reset;
  logic        p0_req, p0_wren, p0_gnt, p0_rvalid;
  logic [15:0] p0_address;
  logic [31:0] p0_data, p0_q;
  logic        p1_req, p1_wren, p1_gnt, p1_rvalid;
  logic [15:0] p1_address;
  logic [31:0] p1_data, p1_q;
  logic [15:0] ram_address;
  logic [31:0] ram_data, ram_q;
  logic        ram_wren;

  logic [31:0] mem [0:255];
  logic [31:0] rpipe [0:LAT-1];

  int n_assert = 0;
  int n_fail   = 0;

  ram_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(LAT)) dut (
    .clock      (clock),
    .reset      (reset),
    .p0_req     (p0_req),
    .p0_wren    (p0_wren),
    .p0_address (p0_address),
    .p0_data    (p0_data),
    .p0_gnt     (p0_gnt),
    .p0_rvalid  (p0_rvalid),
    .p0_q       (p0_q),
    .p1_req     (p1_req),
    .p1_wren    (p1_wren),
    .p1_address (p1_address),
    .p1_data    (p1_data),
    .p1_gnt     (p1_gnt),
    .p1_rvalid  (p1_rvalid),
    .p1_q       (p1_q),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model; preload contents are (re)written while reset is high
  always @(posedge clock) begin
    if (reset) begin
      mem[1] <= 32'hABCDEF01;
      mem[2] <= 32'h00000002;
      for (int i = 0; i < 8; i++) mem[32+i] <= 32'hC0DE0000 + i;
    end else if (ram_wren) begin
      mem[ram_address[7:0]] <= ram_data;
    end
    rpipe[0] <= mem[ram_address[7:0]];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_q = rpipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}
  task automatic ochk(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, {28'd0, exp});
  endtask

  task automatic step(input logic rst,
                      input logic r0, input logic w0,
                      input logic [15:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1,
                      input logic [15:0] a1, input logic [31:0] d1);
    @(posedge clock);
    #1;
    reset      = rst;
    p0_req     = r0;
    p0_wren    = w0;
    p0_address = a0;
    p0_data    = d0;
    p1_req     = r1;
    p1_wren    = w1;
    p1_address = a1;
    p1_data    = d1;
    @(negedge clock);
  endtask

  task automatic idle(input logic rst);
    step(rst, 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    p0_req = 0; p0_wren = 0; p0_address = '0; p0_data = '0;
    p1_req = 0; p1_wren = 0; p1_address = '0; p1_data = '0;

    // reset holds grants, returns and write enable low
    step(1, 1, 1, 16'h5, 32'h1, 1, 1, 16'h6, 32'h2);
    ochk("rst_out", 4'b0000);
    chk("rst_wren", {31'd0, ram_wren}, 32'd0);
    idle(1);

    // single write
    step(0, 1, 1, 16'h0000, 32'h12345678, 0, 0, 16'h0, 32'h0);
    ochk("wr0_gnt", 4'b1000);
    chk("wr0_wren", {31'd0, ram_wren}, 32'd1);
    chk("wr0_addr", {16'd0, ram_address}, 32'h0);
    chk("wr0_data", ram_data, 32'h12345678);

    // read it back
    step(0, 1, 0, 16'h0000, 32'h0, 0, 0, 16'h0, 32'h0);
    ochk("rd0_gnt", 4'b1000);
    chk("rd0_wren", {31'd0, ram_wren}, 32'd0);
    idle(0);
    ochk("rd0_wait", 4'b0000);
    chk("idle_addr", {16'd0, ram_address}, 32'h0);
    chk("idle_data", ram_data, 32'h0);
    chk("idle_wren", {31'd0, ram_wren}, 32'd0);
    idle(0);
    ochk("rd0_ret", 4'b0010);
    chk("rd0_q", p0_q, 32'h12345678);
    idle(0);
    ochk("rd0_once", 4'b0000);

    // both ports reading continuously: strict alternation
    idle(1);
    for (int i = 0; i < 8; i++) begin
      logic rq, ev, rv;
      rq = (i < 6);
      ev = (i % 2 == 0);
      rv = (i >= 2);
      step(0, rq, 0, 16'h0001, 32'h0, rq, 0, 16'h0002, 32'h0);
      ochk($sformatf("alt_%0d", i), {rq & ev, rq & ~ev, rv & ev, rv & ~ev});
      if (rv && ev) chk($sformatf("alt_q0_%0d", i), p0_q, 32'hABCDEF01);
      if (rv && !ev) chk($sformatf("alt_q1_%0d", i), p1_q, 32'h00000002);
    end
    idle(0);
    ochk("alt_drain", 4'b0000);

    // simultaneous writes after reset, then read back
    idle(1);
    step(0, 1, 1, 16'h0010, 32'hAAAA0000, 1, 1, 16'h0011, 32'h5555FFFF);
    ochk("dw_p0", 4'b1000);
    chk("dw_p0_addr", {16'd0, ram_address}, 32'h10);
    chk("dw_p0_data", ram_data, 32'hAAAA0000);
    step(0, 0, 0, 16'h0, 32'h0, 1, 1, 16'h0011, 32'h5555FFFF);
    ochk("dw_p1", 4'b0100);
    chk("dw_p1_addr", {16'd0, ram_address}, 32'h11);
    chk("dw_p1_data", ram_data, 32'h5555FFFF);
    chk("dw_p1_wren", {31'd0, ram_wren}, 32'd1);
    step(0, 1, 0, 16'h0010, 32'h0, 1, 0, 16'h0011, 32'h0);
    ochk("dr_p0", 4'b1000);
    step(0, 0, 0, 16'h0, 32'h0, 1, 0, 16'h0011, 32'h0);
    ochk("dr_p1", 4'b0100);
    idle(0);
    ochk("dr_ret0", 4'b0010);
    chk("dr_q0", p0_q, 32'hAAAA0000);
    idle(0);
    ochk("dr_ret1", 4'b0001);
    chk("dr_q1", p1_q, 32'h5555FFFF);

    // reset while a p1 read is in flight
    step(0, 0, 0, 16'h0, 32'h0, 1, 0, 16'h0002, 32'h0);
    ochk("fl_gnt", 4'b0100);
    idle(1);
    ochk("fl_rst", 4'b0000);
    step(0, 1, 0, 16'h0001, 32'h0, 1, 0, 16'h0002, 32'h0);
    ochk("fl_dual", 4'b1000);
    idle(0);
    ochk("fl_drop", 4'b0000);
    idle(0);
    ochk("fl_ret", 4'b0010);
    chk("fl_q0", p0_q, 32'hABCDEF01);
    idle(0);
    ochk("fl_end", 4'b0000);

    // single requester streaming 8 reads
    for (int i = 0; i < 10; i++) begin
      logic rq, rv;
      rq = (i < 8);
      rv = (i >= 2);
      step(0, 0, 0, 16'h0, 32'h0, rq, 0, 16'h0020 + 16'(i), 32'h0);
      ochk($sformatf("str_%0d", i), {1'b0, rq, 1'b0, rv});
      if (rv) chk($sformatf("str_q_%0d", i), p1_q, 32'hC0DE0000 + 32'(i - 2));
    end
    idle(0);
    ochk("str_end", 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 The block SHALL have parameter READ_LAT, default 2, RAM read latency in cycles (legal 1..4).
REQ-004 The block SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have ports p0_req / p1_req  in  1  access request, held until granted.
REQ-007 The block SHALL have ports p0_wren / p1_wren  in  1  1 = write, 0 = read; valid with req.
REQ-008 The block SHALL have ports p0_address / p1_address  in  ADDR_W  word address; valid with req.
REQ-009 The block SHALL have ports p0_data / p1_data  in  DATA_W  write data; valid with req and wren.
REQ-010 The block SHALL have ports p0_gnt / p1_gnt  out  1  request accepted this cycle.
REQ-011 The block SHALL have ports p0_rvalid / p1_rvalid  out  1  read data valid this cycle.
REQ-012 The block SHALL have ports p0_q / p1_q  out  DATA_W  read data, meaningful only with rvalid.
REQ-013 The block SHALL have port ram_address  out  ADDR_W  to RAM address.
REQ-014 The block SHALL have port ram_data  out  DATA_W  to RAM write data.
REQ-015 The block SHALL have port ram_wren  out  1  to RAM write enable.
REQ-016 The block SHALL have port ram_q  in  DATA_W  from RAM read data.

Function
REQ-017 At most one of p0_gnt/p1_gnt SHALL be high in any cycle; gnt is combinational from req and the priority register.
REQ-018 Single requester: gnt high in the same cycle as req.
REQ-019 Both requesting: grant goes to the port named by priority register prio; the other waits.
REQ-020 After any grant, prio SHALL update to the non-granted port index (round-robin); with no grant, prio holds.
REQ-021 In a grant cycle, ram_address/ram_data/ram_wren SHALL be the granted port's address/data/wren, combinationally, so the RAM samples them at that cycle's closing edge.
REQ-022 No grant: ram_wren = 0, ram_address = 0, ram_data = 0.
REQ-023 Read granted in cycle N: the owning port's rvalid SHALL be high for exactly one cycle, N+READ_LAT, with pX_q = ram_q in that cycle.
REQ-024 Writes SHALL never produce rvalid.
REQ-025 A READ_LAT-deep tag pipeline (valid bit + port id) SHALL track in-flight reads; back-to-back reads, one per cycle, SHALL be supported with no bubbles.
REQ-026 Returns SHALL be in issue order; both rvalids never high in the same cycle.
REQ-027 pX_q SHALL be driven from ram_q; no data buffering in the block.
REQ-028 A requester deasserting req before grant SHALL be legal; no access is issued for it.

Reset
REQ-029 With reset high at a rising edge: prio <= 0, all tag-pipeline valid bits <= 0.
REQ-030 During any cycle with reset high, both gnt, both rvalid and ram_wren SHALL be 0.
REQ-031 Reads in flight when reset asserts SHALL be discarded; no rvalid for them after reset releases.
REQ-032 First cycle after reset release with both requesting: port 0 granted.

Verification
REQ-033 Reset, then p0 write addr 0x0000 data 0x12345678 -> p0_gnt same cycle, ram_wren=1, ram_address=0x0000, no rvalid.
REQ-034 p0 read addr 0x0000 after REQ-033 write -> p0_rvalid exactly READ_LAT cycles after grant, p0_q = 0x12345678.
REQ-035 Both ports read continuously for 6 cycles (p0 addr 0x0001, p1 addr 0x0002, preloaded 0xABCDEF01 / 0x00000002) -> grants alternate p0,p1,p0,...; rvalids alternate, each with its port's correct data.
REQ-036 Both ports write same cycle after reset (p0 0x0010<-0xAAAA0000, p1 0x0011<-0x5555FFFF) -> p0 granted first, p1 next cycle; read-back returns both values.
REQ-037 Issue p1 read, assert reset 1 cycle later for 1 cycle -> no p1_rvalid ever appears; next dual request grants p0.
REQ-038 Single requester streaming 8 reads -> gnt high all 8 cycles, 8 consecutive rvalids, correct data each.
